layer_scanout: RTL and testbench

LAYER_SCANOUT -- requirements
Module: layer_scanout

---
 rtl/layer_scanout.sv | 150 +++++++++++++++
 tb/tb_layer_scanout.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scanout.sv
// rtl/layer_scanout.sv - layer buffer frame readout: SRAM chunk reads to a 256x256 pixel stream.
// Optional build macro SCANOUT_COLORKEY_EN blanks the 24'hFF00FF colour key to black.
module layer_scanout #(
    parameter int ADDR_SIZE_BITS  = 18,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64
) (
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic                                       start,
    input  logic                                       layer_num,
    output logic                                       busy,
    output logic                                       frame_done,
    output logic                                       read_enable,
    output logic [ADDR_SIZE_BITS-1:0]                  address,
    input  logic                                       read_valid,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic                                       pix_valid,
    input  logic                                       pix_ready,
    output logic [23:0]                                pix_data,
    output logic [7:0]                                 pix_x,
    output logic [7:0]                                 pix_y
);

    localparam int PIX_W = WORD_SIZE_BYTES * 8;
    localparam int BUF_W = PIX_W * DATA_SIZE_WORDS;
    localparam int IDX_W = $clog2(DATA_SIZE_WORDS);
    localparam logic [IDX_W-1:0]          LAST_IDX    = IDX_W'(DATA_SIZE_WORDS - 1);
    localparam logic [IDX_W-1:0]          IDX_ONE     = IDX_W'(1);
    localparam logic [7:0]                CHUNK_X     = 8'(DATA_SIZE_WORDS);
    localparam logic [7:0]                LAST_X      = 8'(256 - DATA_SIZE_WORDS);
    localparam logic [ADDR_SIZE_BITS-1:0] LAYER1_BASE = ADDR_SIZE_BITS'(65536);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic [ADDR_SIZE_BITS-1:0] r_base;
    logic [7:0]                r_x;
    logic [7:0]                r_y;
    logic [IDX_W-1:0]          r_idx;
    logic [BUF_W-1:0]          r_buf;

    logic [IDX_W-1:0]          w_idx_next;
    logic [7:0]                w_x_next;
    logic [7:0]                w_y_next;
    logic                      w_last_chunk;
    logic [ADDR_SIZE_BITS-1:0] w_next_addr;
    logic [ADDR_SIZE_BITS-1:0] w_start_base;
    logic [23:0]               w_buf_pix;

    function automatic logic [23:0] f_key(input logic [23:0] p);
`ifdef SCANOUT_COLORKEY_EN
        return (p == 24'hFF00FF) ? 24'h000000 : p;
`else
        return p;
`endif
    endfunction

    // x wraps on the 8-bit add; the carry out of the last chunk moves to the next row
    assign w_idx_next   = r_idx + IDX_ONE;
    assign w_x_next     = r_x + CHUNK_X;
    assign w_y_next     = (r_x == LAST_X) ? r_y + 8'd1 : r_y;
    assign w_last_chunk = (r_y == 8'hFF) && (r_x == LAST_X);
    assign w_next_addr  = r_base + ADDR_SIZE_BITS'({w_y_next, w_x_next});
    assign w_start_base = layer_num ? LAYER1_BASE : '0;
    assign w_buf_pix    = r_buf[int'(w_idx_next) * PIX_W +: 24];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_idx       <= '0;
            r_buf       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            read_enable <= 1'b0;
            address     <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        r_base      <= w_start_base;
                        r_x         <= '0;
                        r_y         <= '0;
                        busy        <= 1'b1;
                        read_enable <= 1'b1;
                        address     <= w_start_base;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    read_enable <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (read_valid) begin
                        r_buf     <= read_data;
                        r_idx     <= '0;
                        pix_valid <= 1'b1;
                        pix_data  <= f_key(read_data[23:0]);
                        pix_x     <= r_x;
                        pix_y     <= r_y;
                        r_state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (pix_ready) begin
                        if (r_idx == LAST_IDX) begin
                            pix_valid <= 1'b0;
                            r_x       <= w_x_next;
                            r_y       <= w_y_next;
                            if (w_last_chunk) begin
                                frame_done <= 1'b1;
                                r_state    <= S_DONE;
                            end else begin
                                read_enable <= 1'b1;
                                address     <= w_next_addr;
                                r_state     <= S_REQ;
                            end
                        end else begin
                            r_idx    <= w_idx_next;
                            pix_data <= f_key(w_buf_pix);
                            pix_x    <= pix_x + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_scanout.sv
// tb/tb_layer_scanout.sv - directed/random bench for layer_scanout against a raster-order pixel model.
module tb_layer_scanout;

    localparam int AW = 18;
    localparam int DW = 3 * 64 * 8;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic          layer_num;
    logic          busy;
    logic          frame_done;
    logic          read_enable;
    logic [AW-1:0] address;
    logic          read_valid;
    logic [DW-1:0] read_data;
    logic          pix_valid;
    logic          pix_ready;
    logic [23:0]   pix_data;
    logic [7:0]    pix_x;
    logic [7:0]    pix_y;

    int total = 0;
    int bad   = 0;
    int re_cnt = 0;
    int fd_cnt = 0;
    logic [23:0] mp [64];
    logic [DW-1:0] rd_buf;

    layer_scanout dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .layer_num  (layer_num),
        .busy       (busy),
        .frame_done (frame_done),
        .read_enable(read_enable),
        .address    (address),
        .read_valid (read_valid),
        .read_data  (read_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] exp_pix(input logic [23:0] p);
`ifdef SCANOUT_COLORKEY_EN
        return (p == 24'hFF00FF) ? 24'h000000 : p;
`else
        return p;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock; outputs observed 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (read_enable) re_cnt++;
        if (frame_done) fd_cnt++;
        if (n_rst) chk("no_overlap", {31'b0, read_enable & pix_valid}, 32'd0);
    endtask

    task automatic make_chunk(input bit force_key);
        for (int j = 0; j < 64; j++) begin
            logic [23:0] p;
            p = 24'($urandom);
            if ($urandom_range(0, 15) == 0) p = 24'hFF00FF;
            if (j == 0 && force_key) p = 24'hFF00FF;
            mp[j] = p;
            rd_buf[j*24 +: 24] = p;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_frame_done"}, {31'b0, frame_done}, 0);
        chk({tag, "_read_enable"}, {31'b0, read_enable}, 0);
        chk({tag, "_address"}, 32'(address), 0);
        chk({tag, "_pix_valid"}, {31'b0, pix_valid}, 0);
        chk({tag, "_pix_data"}, 32'(pix_data), 0);
        chk({tag, "_pix_x"}, 32'(pix_x), 0);
        chk({tag, "_pix_y"}, 32'(pix_y), 0);
    endtask

    // Serve one chunk read (data two cycles after the request) and walk n_pix pixels.
    task automatic run_chunk(input int cx, input int cy, input int exp_addr, input int n_pix,
                             input bit stall, input bit pulse, input bit force_key);
        int n;
        n = 0;
        while (!read_enable && n < 20) begin
            step();
            n++;
        end
        chk("read_enable_seen", {31'b0, read_enable}, 1);
        chk("address", 32'(address), 32'(exp_addr));
        step();
        chk("read_enable_one_cycle", {31'b0, read_enable}, 0);
        step();
        make_chunk(force_key);
        read_valid = 1'b1;
        read_data  = rd_buf;
        step();
        read_valid = 1'b0;
        read_data  = {48{32'hDEADBEEF}};
        for (int j = 0; j < n_pix; j++) begin
            chk("pix_valid", {31'b0, pix_valid}, 1);
            chk("pix_data", 32'(pix_data), 32'(exp_pix(mp[j])));
            chk("pix_x", 32'(pix_x), 32'(cx + j));
            chk("pix_y", 32'(pix_y), 32'(cy));
            if (stall && j == 5) begin
                pix_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("stall_data", 32'(pix_data), 32'(exp_pix(mp[5])));
                    chk("stall_x", 32'(pix_x), 32'(cx + 5));
                    chk("stall_valid", {31'b0, pix_valid}, 1);
                end
                pix_ready = 1'b1;
            end
            if (pulse && j == 20) begin
                start      = 1'b1;
                layer_num  = 1'b0;
                read_valid = 1'b1;
                step();
                start      = 1'b0;
                layer_num  = 1'b1;
                read_valid = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        int re0;
        int fd0;
        n_rst      = 1'b0;
        start      = 1'b0;
        layer_num  = 1'b0;
        read_valid = 1'b0;
        read_data  = '0;
        pix_ready  = 1'b1;
        rd_buf     = '0;
        step();
        step();
        check_reset_outputs("reset");
        n_rst = 1'b1;
        step();
        chk("idle_busy", {31'b0, busy}, 0);

        // layer 0: first chunk with a stall at pixel 5 and colour key on pixel 0
        layer_num = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("start_latency_re", {31'b0, read_enable}, 1);
        chk("start_busy", {31'b0, busy}, 1);
        run_chunk(0, 0, 0, 64, 1'b1, 1'b0, 1'b1);
        run_chunk(64, 0, 64, 10, 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of a cycle while streaming
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        step();
        n_rst = 1'b1;
        step();
        chk("post_reset_frame_done", 32'(fd_cnt), 0);

        layer_num = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("restart_re", {31'b0, read_enable}, 1);
        chk("restart_address", 32'(address), 0);
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        step();

        // full layer-1 frame; a stray start and read_valid mid-frame must be ignored
        re0 = re_cnt;
        fd0 = fd_cnt;
        layer_num = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 1024; c++) begin
            int y;
            int x;
            y = c / 4;
            x = (c % 4) * 64;
            run_chunk(x, y, 65536 + y * 256 + x, 64, 1'b0, c == 10, 1'b0);
        end
        chk("frame_done_pulse", {31'b0, frame_done}, 1);
        chk("busy_at_done", {31'b0, busy}, 1);
        step();
        chk("frame_done_low", {31'b0, frame_done}, 0);
        chk("busy_after_done", {31'b0, busy}, 0);
        chk("read_count", 32'(re_cnt - re0), 1024);
        chk("frame_done_count", 32'(fd_cnt - fd0), 1);
        step();
        chk("idle_no_read", {31'b0, read_enable}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
